// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller that owns the HI/LO registers,
// issues pipeline stalls while busy and pulses done when a new result lands.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mulop,
    input  logic [31:0] ind1,
    input  logic [31:0] ind2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_read,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic        r_done;
    logic        w_sgn, w_neg_a, w_neg_b;
    logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_quo, w_rem;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [3:0]  w_lat;
    assign w_sgn   = ~r_op[0];
    assign w_neg_a = w_sgn & r_a[31];
    assign w_neg_b = w_sgn & r_b[31];
    // Low 64 bits of an extended product are correct for both signed and unsigned.
    assign w_ext_a = {{32{w_neg_a}}, r_a};
    assign w_ext_b = {{32{w_neg_b}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;
    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
    assign w_abs_a = w_neg_a ? -r_a : r_a;
    assign w_abs_b = w_neg_b ? -r_b : r_b;
    assign w_q     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
    assign w_r     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    assign w_rem   = w_neg_a ? -w_r : w_r;
    assign w_lat   = mulop[1] ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_op    <= mulop;
                    r_a     <= ind1;
                    r_b     <= ind2;
                    r_cnt   <= w_lat;
                    r_state <= BUSY;
                end else begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                end
            end else if (r_cnt == 4'd0) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                if (!r_op[1]) {r_hi, r_lo} <= w_prod;
                else if (w_abs_b != 32'd0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end
    assign busy  = (r_state == BUSY);
    assign stall = reset_n & busy & (start | md_read | hi_we | lo_we);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl with hand-computed results.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mulop = 2'd0;
    logic [31:0] ind1 = 32'd0;
    logic [31:0] ind2 = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        md_read = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
    int          tests = 0;
    int          fails = 0;

    mdu_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mulop(mulop),
        .ind1(ind1), .ind2(ind2), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .md_read(md_read), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        mulop = op;
        ind1  = a;
        ind2  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        ind1  = $urandom;
        ind2  = $urandom;
    endtask

    task automatic run_busy(input int lat, input bit exp_stall, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk1({tag, "_done_low"}, done, 1'b0);
            if (exp_stall) chk1({tag, "_stall"}, stall, 1'b1);
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(lat));
        chk1({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        md_read = 1'b1;
        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset_n = 1'b1;
        #1;
        chk1("post_rst_stall", stall, 1'b0);
        md_read = 1'b0;
        step();

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        chk1("mult_busy", busy, 1'b1);
        run_busy(5, 1'b0, "mult_m3x5");
        chk("mult_m3x5_hi", hi, 32'hFFFF_FFFF);
        chk("mult_m3x5_lo", lo, 32'hFFFF_FFF1);
        step();
        chk1("mult_done_pulse", done, 1'b0);

        issue(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_busy(5, 1'b0, "mult_m2xm3");
        chk("mult_m2xm3_hi", hi, 32'h0);
        chk("mult_m2xm3_lo", lo, 32'd6);

        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        run_busy(5, 1'b0, "mult_min2");
        chk("mult_min2_hi", hi, 32'h4000_0000);
        chk("mult_min2_lo", lo, 32'h0);

        issue(2'b01, 32'hFFFF_FFFF, 32'd2);
        run_busy(5, 1'b0, "multu");
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        chk1("b2b_busy", busy, 1'b1);
        run_busy(5, 1'b0, "b2b");
        chk("b2b_hi", hi, 32'h1);
        chk("b2b_lo", lo, 32'h0);

        md_read = 1'b1;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_busy(10, 1'b1, "div_m7d2");
        chk1("div_stall_after", stall, 1'b0);
        chk("div_m7d2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7d2_hi", hi, 32'hFFFF_FFFF);
        md_read = 1'b0;

        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        run_busy(10, 1'b0, "div_7dm2");
        chk("div_7dm2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7dm2_hi", hi, 32'h1);

        issue(2'b11, 32'd100, 32'd7);
        run_busy(10, 1'b0, "divu");
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(10, 1'b0, "div_ovf");
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        hi_we = 1'b1;
        wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h5678;
        step();
        lo_we = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0);
        run_busy(10, 1'b0, "divz");
        chk("divz_hi", hi, 32'h1234);
        chk("divz_lo", lo, 32'h5678);

        issue(2'b00, 32'd7, 32'd9);
        step();
        step();
        chk1("abort_busy_c3", busy, 1'b1);
        reset_n = 1'b0;
        md_read = 1'b1;
        step();
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_stall", stall, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        reset_n = 1'b1;
        md_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("abort_no_done", done, 1'b0);
            step();
        end
        chk("abort_hi_kept", hi, 32'h0);

        hi_we = 1'b1;
        wdata = 32'hAAAA;
        issue(2'b00, 32'd2, 32'd3);
        hi_we = 1'b0;
        chk("start_wins_hi", hi, 32'h0);
        run_busy(5, 1'b0, "start_wins");
        chk("start_wins_hi_end", hi, 32'h0);
        chk("start_wins_lo_end", lo, 32'd6);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h55;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("both_we_hi", hi, 32'h55);
        chk("both_we_lo", lo, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1);
    end
endmodule
